// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: FSM encoding,
// oversample positions and the bit-vote helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam int OS_RATE = 16;
   localparam int OS_W    = $clog2(OS_RATE);

   localparam logic [OS_W-1:0] SAMPLE_A = 4'd6;
   localparam logic [OS_W-1:0] SAMPLE_B = 4'd7;
   localparam logic [OS_W-1:0] SAMPLE_C = 4'd8;
   localparam logic [OS_W-1:0] BIT_END  = 4'd15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div_i and pulses tick_o on the terminal
// count; clr_i restarts the count so a frame's first tick is aligned to its start edge.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      tick_o    = 1'b0;
      div_cnt_d = div_cnt_q;
      if (clr_i) begin
         div_cnt_d = '0;
      end else if (div_cnt_q == div_i) begin
         div_cnt_d = '0;
         tick_o    = 1'b1;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) div_cnt_q <= '0;
      else          div_cnt_q <= div_cnt_d;
   end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: synchronises rx, votes each bit over three
// mid-bit samples, checks parity/stop and emits one write strobe or error pulse per frame.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             rx,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic             parity_en_i,
   input  logic             parity_odd_i,
   input  logic             full_i,
   output logic [7:0]       data_o,
   output logic             we_o,
   output logic             frame_err_o,
   output logic             parity_err_o,
   output logic             overrun_o,
   output logic             busy_o,
   output logic [2:0]       dbg_state_o
);

   // we_o is a push-only strobe: one hclk wide, data_o valid with it; the FIFO
   // has no ready, so full_i is honoured by dropping the byte and pulsing overrun_o.

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rx_prev_q;
   state_e                 state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic                   par_en_q, par_en_d, par_odd_q, par_odd_d;
   logic [OS_W-1:0]        s_cnt_q, s_cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shreg_q, shreg_d, data_q, data_d;
   logic                   smp_a_q, smp_a_d, smp_b_q, smp_b_d;
   logic                   perr_q, perr_d;
   logic                   we_q, we_d, fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

   logic rx_s, start_edge, tick, voted, mid_tick, end_tick, div_clr;

   assign sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign start_edge = rx_prev_q & ~rx_s;
   assign voted      = majority3(smp_a_q, smp_b_q, rx_s);
   assign mid_tick   = tick && (s_cnt_q == SAMPLE_C);
   assign end_tick   = tick && (s_cnt_q == BIT_END);
   assign div_clr    = (state_q == ST_IDLE) && start_edge;

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
      .hclk    (hclk),
      .hresetn (hresetn),
      .clr_i   (div_clr),
      .div_i   (div_q),
      .tick_o  (tick)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
         state_q   <= ST_IDLE;
         div_q     <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         s_cnt_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         smp_a_q   <= 1'b0;
         smp_b_q   <= 1'b0;
         perr_q    <= 1'b0;
         data_q    <= '0;
         we_q      <= 1'b0;
         fe_q      <= 1'b0;
         pe_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         div_q     <= div_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         s_cnt_q   <= s_cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         smp_a_q   <= smp_a_d;
         smp_b_q   <= smp_b_d;
         perr_q    <= perr_d;
         data_q    <= data_d;
         we_q      <= we_d;
         fe_q      <= fe_d;
         pe_q      <= pe_d;
         ov_q      <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_edge) state_d = ST_START;
         ST_START: begin
            if (mid_tick && voted) state_d = ST_IDLE;
            else if (end_tick)     state_d = ST_DATA;
         end
         ST_DATA:   if (end_tick && (bit_idx_q == 3'd7)) state_d = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (end_tick) state_d = ST_STOP;
         // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
         ST_STOP:   if (mid_tick) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      div_d     = div_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      s_cnt_d   = s_cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      smp_a_d   = smp_a_q;
      smp_b_d   = smp_b_q;
      perr_d    = perr_q;
      data_d    = data_q;
      we_d      = 1'b0;
      fe_d      = 1'b0;
      pe_d      = 1'b0;
      ov_d      = 1'b0;

      if (div_clr) begin
         div_d     = baud_div_i;
         par_en_d  = parity_en_i;
         par_odd_d = parity_odd_i;
         s_cnt_d   = '0;
         perr_d    = 1'b0;
      end else if ((state_q != ST_IDLE) && tick) begin
         s_cnt_d = s_cnt_q + OS_W'(1);
         if (s_cnt_q == SAMPLE_A) smp_a_d = rx_s;
         if (s_cnt_q == SAMPLE_B) smp_b_d = rx_s;
      end

      case (state_q)
         ST_START: if (end_tick) bit_idx_d = '0;
         ST_DATA: begin
            if (mid_tick) shreg_d = {voted, shreg_q[7:1]};
            if (end_tick) bit_idx_d = bit_idx_q + 3'd1;
         end
         ST_PARITY: if (mid_tick) perr_d = (^shreg_q) ^ voted ^ par_odd_q;
         // Frame error outranks parity, which outranks overrun: one pulse at most.
         ST_STOP: begin
            if (mid_tick) begin
               if (!voted)      fe_d = 1'b1;
               else if (perr_q) pe_d = 1'b1;
               else if (full_i) ov_d = 1'b1;
               else begin
                  we_d   = 1'b1;
                  data_d = shreg_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign data_o       = data_q;
   assign we_o         = we_q;
   assign frame_err_o  = fe_q;
   assign parity_err_o = pe_q;
   assign overrun_o    = ov_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: drives serial frames, predicts each frame's single
// outcome from the line format rules and matches it against observed pulses.
module tb_uart_rx_os16;

   localparam int DIV_W = 16;
   localparam logic [1:0] K_WE = 2'd0, K_FE = 2'd1, K_PE = 2'd2, K_OV = 2'd3;

   logic             hclk = 1'b0;
   logic             hresetn = 1'b0;
   logic             rx = 1'b1;
   logic [DIV_W-1:0] baud_div_i = '0;
   logic             parity_en_i = 1'b0;
   logic             parity_odd_i = 1'b0;
   logic             full_i = 1'b0;
   logic [7:0]       data_o;
   logic             we_o, frame_err_o, parity_err_o, overrun_o, busy_o;
   logic [2:0]       dbg_state_o;

   uart_rx_os16 #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
      .hclk         (hclk),
      .hresetn      (hresetn),
      .rx           (rx),
      .baud_div_i   (baud_div_i),
      .parity_en_i  (parity_en_i),
      .parity_odd_i (parity_odd_i),
      .full_i       (full_i),
      .data_o       (data_o),
      .we_o         (we_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 hclk = ~hclk;

   int cyc = 0;
   always @(posedge hclk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: sim time limit reached, state=%0d", dbg_state_o);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_chk = 0;
   int n_err = 0;
   logic [9:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference outcome of one frame, straight from the line format rules.
   function automatic logic [9:0] model(input logic [7:0] d, input logic pen, input logic podd,
                                        input logic pbit, input logic stop, input logic full);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += d[i];
      if (!stop) return {K_FE, 8'h00};
      if (pen && (((ones + pbit) % 2) != (podd ? 1 : 0))) return {K_PE, 8'h00};
      if (full) return {K_OV, 8'h00};
      return {K_WE, d};
   endfunction

   // ---------------- monitor ----------------
   int n_evt = 0;
   int last_evt_cyc = 0;
   int busy_fall_cyc = 0;
   int busy_hi_cnt = 0;
   logic busy_prev = 1'b0;

   always @(negedge hclk) begin
      if (hresetn) begin
         int npulse;
         logic [9:0] obs;
         npulse = int'(we_o) + int'(frame_err_o) + int'(parity_err_o) + int'(overrun_o);
         if (busy_o) busy_hi_cnt++;
         if (busy_prev && !busy_o) busy_fall_cyc = cyc;
         if (npulse != 0) begin
            n_evt++;
            last_evt_cyc = cyc;
            check("pulses_per_cycle", npulse, 1);
            if (we_o)              obs = {K_WE, data_o};
            else if (frame_err_o)  obs = {K_FE, 8'h00};
            else if (parity_err_o) obs = {K_PE, 8'h00};
            else                   obs = {K_OV, 8'h00};
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_event: got kind=%0d data=0x%0h, expected none", obs[9:8], obs[7:0]);
            end else begin
               check("event", int'(obs), int'(exp_q.pop_front()));
            end
         end
      end
      busy_prev = busy_o;
   end

   // ---------------- drivers ----------------
   int start_cyc = 0;

   task automatic bit_out(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge hclk);
      #1;
   endtask

   task automatic set_cfg(input int div, input logic pen, input logic podd, input logic full);
      baud_div_i   = DIV_W'(div);
      parity_en_i  = pen;
      parity_odd_i = podd;
      full_i       = full;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stop, input int div, input int gap, input bit scramble);
      int bc;
      bc = 16 * (div + 1);
      if (gap > 0) bit_out(1'b1, gap);
      start_cyc = cyc + 1;
      bit_out(1'b0, bc / 2);
      if (scramble) begin
         baud_div_i   = DIV_W'($urandom_range(0, 7));
         parity_en_i  = 1'($urandom_range(0, 1));
         parity_odd_i = 1'($urandom_range(0, 1));
      end
      bit_out(1'b0, bc - bc / 2);
      for (int i = 0; i < 8; i++) bit_out(d[i], bc);
      if (pen) bit_out(pbit, bc);
      bit_out(stop, bc);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       podd;
      logic       pbit;
      logic       stop;
      logic       full;
      logic [1:0] exp_kind;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int evt0;
      tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, K_PE, 8'h00};
      tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, K_WE, 8'h3C};
      tbl[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_FE, 8'h00};
      tbl[3] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, K_OV, 8'h00};
      tbl[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, K_PE, 8'h00};
      tbl[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_FE, 8'h00};
      tbl[6] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, K_WE, 8'h07};
      tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, K_WE, 8'h00};
      tbl[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, K_WE, 8'hFF};

      // Reset state
      repeat (3) @(posedge hclk);
      #1;
      check("rst_data", data_o, 8'h00);
      check("rst_we", we_o, 0);
      check("rst_errs", {frame_err_o, parity_err_o, overrun_o}, 0);
      check("rst_busy", busy_o, 0);
      hresetn = 1'b1;
      bit_out(1'b1, 8);
      check("idle_busy", busy_o, 0);

      // 8N1 0xA5 at div=0: strobe and busy fall ~155 hclk after the falling edge
      set_cfg(0, 1'b0, 1'b0, 1'b0);
      evt0 = n_evt;
      exp_q.push_back({K_WE, 8'hA5});
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0);
      bit_out(1'b1, 4);
      check("a5_events", n_evt - evt0, 1);
      check_range("a5_latency", last_evt_cyc - start_cyc, 150, 156);
      check_range("a5_busy_fall", busy_fall_cyc - start_cyc, 150, 156);
      check("a5_drained", exp_q.size(), 0);
      check("a5_data_held", data_o, 8'hA5);

      // False start: 4-tick glitch
      evt0 = n_evt;
      busy_hi_cnt = 0;
      bit_out(1'b0, 4);
      bit_out(1'b1, 40);
      check_range("glitch_busy_cycles", busy_hi_cnt, 1, 10);
      check("glitch_events", n_evt - evt0, 0);
      check("glitch_idle", busy_o, 0);

      // Table of single frames at div=0
      for (int i = 0; i < 9; i++) begin
         set_cfg(0, tbl[i].pen, tbl[i].podd, tbl[i].full);
         exp_q.push_back({tbl[i].exp_kind, tbl[i].exp_data});
         send_frame(tbl[i].data, tbl[i].pen, tbl[i].pbit, tbl[i].stop, 0, 4, 1'b0);
         bit_out(1'b1, 4);
         check($sformatf("tbl%0d_drained", i), exp_q.size(), 0);
      end

      // Frame error followed by a 40 bit-time break, then a good byte
      set_cfg(0, 1'b0, 1'b0, 1'b0);
      evt0 = n_evt;
      exp_q.push_back({K_FE, 8'h00});
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0);
      bit_out(1'b0, 640);
      check("break_events", n_evt - evt0, 1);
      check("break_idle", busy_o, 0);
      bit_out(1'b1, 20);
      exp_q.push_back({K_WE, 8'h55});
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
      bit_out(1'b1, 4);
      check("break_total_events", n_evt - evt0, 2);
      check("break_drained", exp_q.size(), 0);

      // Overrun, then two back-to-back good frames
      set_cfg(0, 1'b0, 1'b0, 1'b1);
      exp_q.push_back({K_OV, 8'h00});
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0);
      full_i = 1'b0;
      evt0 = n_evt;
      exp_q.push_back({K_WE, 8'h01});
      exp_q.push_back({K_WE, 8'h02});
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0);
      send_frame(8'h02, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
      bit_out(1'b1, 4);
      check("b2b_events", n_evt - evt0, 2);
      check("b2b_drained", exp_q.size(), 0);

      // div=3: reset asserted during bit 4, then a clean 0xC3
      set_cfg(3, 1'b0, 1'b0, 1'b0);
      evt0 = n_evt;
      bit_out(1'b1, 4);
      bit_out(1'b0, 64);
      for (int i = 0; i < 4; i++) bit_out(1'((8'h5A >> i) & 8'h01), 64);
      bit_out(1'b0, 20);
      check("pre_rst_busy", busy_o, 1);
      hresetn = 1'b0;
      #1;
      check("midrst_busy", busy_o, 0);
      check("midrst_data", data_o, 8'h00);
      check("midrst_pulses", {we_o, frame_err_o, parity_err_o, overrun_o}, 0);
      rx = 1'b1;
      repeat (5) @(posedge hclk);
      #1;
      hresetn = 1'b1;
      bit_out(1'b1, 8);
      check("midrst_events", n_evt - evt0, 0);
      exp_q.push_back({K_WE, 8'hC3});
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 3, 4, 1'b0);
      bit_out(1'b1, 8);
      check_range("c3_latency_div3", last_evt_cyc - start_cyc, 600, 624);
      check("c3_drained", exp_q.size(), 0);

      // Random frames with config scrambled mid-frame, checked against the model
      for (int n = 0; n < 16; n++) begin
         int div;
         logic [7:0] d;
         logic pen, podd, pbit, stop, full;
         div  = $urandom_range(0, 2);
         d    = 8'($urandom_range(0, 255));
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         pbit = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 5) != 0);
         full = ($urandom_range(0, 3) == 0);
         set_cfg(div, pen, podd, full);
         exp_q.push_back(model(d, pen, podd, pbit, stop, full));
         send_frame(d, pen, pbit, stop, div, $urandom_range(2, 12), 1'b1);
         bit_out(stop, 4);
         check($sformatf("rnd%0d_drained", n), exp_q.size(), 0);
      end

      bit_out(1'b1, 50);
      check("final_drained", exp_q.size(), 0);
      check("final_idle", busy_o, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 16x-oversampling UART receiver feeding the receive FIFO of the AHB UART slave.
- Synchronises the asynchronous rx pin, detects start bits, majority-votes each bit, and checks parity and stop bit.
- Pushes good bytes with a one-cycle write strobe gated by FIFO full.
- Reports framing, parity and overrun errors as single-cycle pulses for the slave's status/interrupt logic.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- SYNC_STAGES, 2, number of rx synchroniser flops (minimum 2).

Ports:
- hclk  input  1  system clock.
- hresetn  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line, asynchronous, idle high.
- baud_div_i  input  DIV_W  oversample tick period minus 1, in hclk cycles.
- parity_en_i  input  1  1 = parity bit present after data.
- parity_odd_i  input  1  1 = odd parity, 0 = even.
- full_i  input  1  receive FIFO full.
- data_o  output  8  received byte; valid while we_o=1, held afterwards.
- we_o  output  1  one-cycle FIFO write strobe.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err_o  output  1  one-cycle pulse: parity mismatch.
- overrun_o  output  1  one-cycle pulse: good byte dropped because full_i=1.
- busy_o  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values:
  - all outputs 0; data_o = 8'h00.
  - synchroniser flops = 1.
  - state IDLE; all counters 0.
- Tick generator:
  - div_cnt counts 0..div_q; tick is a one-cycle pulse when div_cnt == div_q, then div_cnt wraps to 0.
  - div_q = 0 gives a tick every hclk, i.e. 1 bit = 16 hclk.
- Frame-start latching:
  - On start-edge detection, baud_div_i, parity_en_i and parity_odd_i are latched (div_q, par_en_q, par_odd_q).
  - div_cnt and s_cnt clear on that edge.
  - Configuration changes mid-frame have no effect.
- s_cnt (4-bit) increments on each tick and wraps 15 -> 0.
- Bit sampling: synchronised rx is sampled at ticks s_cnt = 6, 7, 8; the bit value is the majority of the three, decided on the s_cnt = 8 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Falling edge of synchronised rx (previous 1, current 0) -> START.
  - A continuously low line never triggers.
- START:
  - Voted bit 1 -> IDLE (false start, no pulses).
  - Voted bit 0 -> wait for s_cnt 15 tick -> DATA with bit_idx = 0.
- DATA:
  - 8 bits, LSB first, shifted into shreg; each bit ends on its s_cnt 15 tick.
  - After bit_idx 7: -> PARITY if par_en_q, else -> STOP.
- PARITY:
  - perr = ^shreg ^ parity_bit ^ par_odd_q; a non-zero result is a mismatch.
  - perr is latched; -> STOP at s_cnt 15.
- STOP: the decision is taken on the s_cnt 8 tick, with outputs registered and asserted the next hclk, then -> IDLE.
  - Voted stop = 0 -> frame_err_o only; no other pulse, no we_o.
  - Stop = 1 and perr -> parity_err_o only; byte discarded.
  - Stop = 1, no perr, full_i = 1 -> overrun_o only; byte discarded.
  - Otherwise -> we_o = 1 and data_o = shreg.
- Priority when errors coincide: frame > parity > overrun; exactly one pulse per frame at most.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught.
  - Line held low after a frame error (break) is ignored until it rises and falls again.
- full_i is sampled only at the STOP decision.
- Reset mid-frame: immediate return to reset values; no pulse is emitted for the partial frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - OS_RATE = 16, SAMPLE_A/B/C = 6/7/8, BIT_END = 15.
- One sub-module, uart_baud_tick: divisor counter with sync clear and tick output.
- Synchroniser and FSM stay in uart_rx_os16.

Test Plan:
- div=0, 8N1, send 0xA5 -> exactly one we_o with data_o=0xA5, between 150 and 156 hclk after the rx falling edge; busy_o falls in the same window.
- rx low pulse lasting 4 ticks, then high -> START votes 1, returns to IDLE; no we_o and no error pulse; busy_o high for ≤ 10 cycles.
- par_en=1, even parity, send 0x3C with parity bit 1 -> parity_err_o pulse only, no we_o; resend 0x3C with parity bit 0 -> we_o with 0x3C.
- Send 0x81 with stop=0 -> frame_err_o pulse only; hold rx low 40 bit-times, then release, then send 0x55 -> we_o with 0x55 only.
- full_i=1, send 0x01 -> overrun_o only; then full_i=0, send 0x01 and 0x02 back-to-back (idle = 0) -> two we_o pulses with 0x01 then 0x02.
- div=3, send 0x5A and assert hresetn low during bit 4 -> all outputs 0 and busy_o 0 immediately; after release, send 0xC3 -> we_o with 0xC3 (64 hclk per bit).
